// File: rtl/exu_alu_pkg.sv
// Shared definitions for the EXU ALU core: operation codes, FSM states and
// small decode helpers used by the core and its iterative datapath.
package exu_alu_pkg;

  localparam int ISA_WIDTH      = 32;
  localparam int ALU_FUNC_WIDTH = 4;

  typedef enum logic [ALU_FUNC_WIDTH-1:0] {
    ALU_NO_FUNC = 4'd0,
    ALU_ADD     = 4'd1,
    ALU_SUB     = 4'd2,
    ALU_EQ      = 4'd3,
    ALU_NE      = 4'd4,
    ALU_LESS_U  = 4'd5,
    ALU_MUL     = 4'd6,
    ALU_MULHU   = 4'd7,
    ALU_DIVU    = 4'd8,
    ALU_REMU    = 4'd9
  } alu_func_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  function automatic logic is_iter_func(input logic [ALU_FUNC_WIDTH-1:0] func);
    case (func)
      ALU_MUL, ALU_MULHU, ALU_DIVU, ALU_REMU: is_iter_func = 1'b1;
      default:                                is_iter_func = 1'b0;
    endcase
  endfunction

  function automatic logic is_div_func(input logic [ALU_FUNC_WIDTH-1:0] func);
    case (func)
      ALU_DIVU, ALU_REMU: is_div_func = 1'b1;
      default:            is_div_func = 1'b0;
    endcase
  endfunction

  // MULHU and REMU both deliver the upper (hi) register of the shared datapath.
  function automatic logic is_hi_func(input logic [ALU_FUNC_WIDTH-1:0] func);
    case (func)
      ALU_MULHU, ALU_REMU: is_hi_func = 1'b1;
      default:             is_hi_func = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/exu_alu_iter.sv
// Iterative datapath: radix-2 shift-add multiply and restoring divide sharing
// one {hi, lo} register pair; one step per cycle for WIDTH cycles.
module exu_alu_iter
  import exu_alu_pkg::*;
#(
  parameter int WIDTH = ISA_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             last,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  logic             active_r;
  logic             div_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] b_r;

  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH:0]   div_shift_s;
  logic [WIDTH-1:0] div_diff_s;
  logic             div_ge_s;
  logic [WIDTH-1:0] hi_next_s;
  logic [WIDTH-1:0] lo_next_s;
  logic             last_s;

  assign last_s = active_r && (cnt_r == CNT_W'(WIDTH - 1));

  // One multiply or divide step; b==0 naturally yields all-ones quotient and remainder a.
  always_comb begin
    mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
    div_shift_s = {hi_r, lo_r[WIDTH-1]};
    div_diff_s  = div_shift_s[WIDTH-1:0] - b_r;
    div_ge_s    = (div_shift_s >= {1'b0, b_r});
    if (div_r) begin
      if (div_ge_s) begin
        hi_next_s = div_diff_s;
        lo_next_s = {lo_r[WIDTH-2:0], 1'b1};
      end else begin
        hi_next_s = div_shift_s[WIDTH-1:0];
        lo_next_s = {lo_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_next_s = mul_sum_s[WIDTH:1];
      lo_next_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
    end
  end

  // Operand load on start, then WIDTH steps; flush or reset abandons the op.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_r <= 1'b0;
      div_r    <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
    end else if (flush) begin
      active_r <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
    end else if (start) begin
      active_r <= 1'b1;
      div_r    <= is_div;
      cnt_r    <= {CNT_W{1'b0}};
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= op_a;
      b_r      <= op_b;
    end else if (active_r) begin
      hi_r <= hi_next_s;
      lo_r <= lo_next_s;
      if (last_s) begin
        active_r <= 1'b0;
        cnt_r    <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end else begin
      active_r <= active_r;
    end
  end

  assign last   = last_s;
  assign res_hi = hi_next_s;
  assign res_lo = lo_next_s;

endmodule

// File: rtl/exu_alu_core.sv
// EXU ALU core: valid/ready front end, single-cycle ops and result register,
// with long ops delegated to exu_alu_iter. One operation in flight at a time.
module exu_alu_core
  import exu_alu_pkg::*;
#(
  parameter int WIDTH = ISA_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          alu_a,
  input  logic [WIDTH-1:0]          alu_b,
  input  logic [ALU_FUNC_WIDTH-1:0] alu_func,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          alu_result,
  output logic                      busy
);

  alu_state_e       state_r;
  alu_state_e       state_next_s;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;
  logic             in_ready_s;
  logic             out_valid_s;
  logic             busy_s;
  logic [WIDTH-1:0] result_r;
  logic             sel_hi_r;

  logic             accept_s;
  logic             iter_op_s;
  logic             iter_last_s;
  logic [WIDTH-1:0] iter_hi_s;
  logic [WIDTH-1:0] iter_lo_s;

  function automatic logic [WIDTH-1:0] single_op(input logic [ALU_FUNC_WIDTH-1:0] func,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    case (func)
      ALU_ADD:    single_op = a + b;
      ALU_SUB:    single_op = a - b;
      ALU_EQ:     single_op = {{(WIDTH-1){1'b0}}, (a == b)};
      ALU_NE:     single_op = {{(WIDTH-1){1'b0}}, (a != b)};
      ALU_LESS_U: single_op = {{(WIDTH-1){1'b0}}, (a < b)};
      default:    single_op = {WIDTH{1'b0}};
    endcase
  endfunction

  assign iter_op_s = is_iter_func(alu_func);
  assign accept_s  = in_valid && (state_r == ST_IDLE) && !flush;

  exu_alu_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .start  (accept_s && iter_op_s),
    .is_div (is_div_func(alu_func)),
    .op_a   (alu_a),
    .op_b   (alu_b),
    .last   (iter_last_s),
    .res_hi (iter_hi_s),
    .res_lo (iter_lo_s)
  );

  // Next-state logic; flush wins over every other transition.
  always_comb begin
    state_next_s = state_r;
    if (flush) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) state_next_s = iter_op_s ? ST_BUSY : ST_DONE;
          else          state_next_s = ST_IDLE;
        end
        ST_BUSY: begin
          if (iter_last_s) state_next_s = ST_DONE;
          else             state_next_s = ST_BUSY;
        end
        ST_DONE: begin
          if (out_ready) state_next_s = ST_IDLE;
          else           state_next_s = ST_DONE;
        end
        default: state_next_s = ST_IDLE;
      endcase
    end
  end

  // Output decode from the next state so the handshake flags come straight from flops.
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    busy_s      = 1'b0;
    case (state_next_s)
      ST_IDLE: in_ready_s  = 1'b1;
      ST_BUSY: busy_s      = 1'b1;
      ST_DONE: out_valid_s = 1'b1;
      default: in_ready_s  = 1'b0;
    endcase
  end

  // State and registered handshake flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
      busy_r      <= busy_s;
    end
  end

  // Result register: single ops load at accept, long ops on their final step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_r <= {WIDTH{1'b0}};
      sel_hi_r <= 1'b0;
    end else if (accept_s) begin
      sel_hi_r <= is_hi_func(alu_func);
      if (!iter_op_s) result_r <= single_op(alu_func, alu_a, alu_b);
      else            result_r <= result_r;
    end else if ((state_r == ST_BUSY) && iter_last_s && !flush) begin
      result_r <= sel_hi_r ? iter_hi_s : iter_lo_s;
    end else begin
      result_r <= result_r;
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign busy       = busy_r;
  assign alu_result = result_r;

endmodule
